cdce62002_spi_ctrl: RTL and testbench

- Power-up configuration sequencer for the CDCE62002 clock synthesizer in the qpsk design.
- On a start pulse it walks the config LUT ROM from address 0 to NUM_WORDS-1.
- Each 32-bit word is shifted out LSB-first on the device's 3-wire SPI (SPI_CLK/SPI_MOSI/SPI_LE); LE is pulsed high after each word to latch it.
- Signals done when the last word has been latched, so downstream PLL/DAC logic can be released.

---
 rtl/cdce62002_spi_ctrl.sv | 139 +++++++++++++
 tb/tb_cdce62002_spi_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdce62002_spi_ctrl.sv
// Power-up configuration sequencer for the CDCE62002: walks the config ROM and
// shifts each 32-bit word out LSB-first on the 3-wire SPI, pulsing LE after each word.
module cdce62002_spi_ctrl #(
    parameter int CLK_DIV   = 4,
    parameter int NUM_WORDS = 6,
    parameter int LE_CYCLES = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    output logic [2:0]  o_rom_addr,
    input  logic [31:0] i_rom_data,
    output logic        o_spi_clk,
    output logic        o_spi_mosi,
    output logic        o_spi_le,
    output logic        o_busy,
    output logic        o_done
);

    localparam int CNT_MAX = (CLK_DIV > LE_CYCLES) ? CLK_DIV : LE_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] LE_LAST   = CW'(LE_CYCLES - 1);
    localparam logic [2:0]    LAST_ADDR = 3'(NUM_WORDS - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [4:0]    bit_cnt, bit_cnt_nxt;
    logic [30:0]   shreg, shreg_nxt;
    logic [2:0]    addr_nxt;
    logic          spi_clk_nxt, mosi_nxt, le_nxt, busy_nxt, done_nxt;

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values computed by the combinational block below.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            o_rom_addr <= '0;
            o_spi_clk  <= 1'b0;
            o_spi_mosi <= 1'b0;
            o_spi_le   <= 1'b1;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shreg      <= shreg_nxt;
            o_rom_addr <= addr_nxt;
            o_spi_clk  <= spi_clk_nxt;
            o_spi_mosi <= mosi_nxt;
            o_spi_le   <= le_nxt;
            o_busy     <= busy_nxt;
            o_done     <= done_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        addr_nxt    = o_rom_addr;
        spi_clk_nxt = o_spi_clk;
        mosi_nxt    = o_spi_mosi;
        le_nxt      = o_spi_le;
        busy_nxt    = o_busy;
        done_nxt    = 1'b0;

        unique case (state)
            IDLE: begin
                addr_nxt = '0;
                if (i_start) begin
                    state_nxt = LOAD;
                    busy_nxt  = 1'b1;
                end
            end
            LOAD: begin
                // Bit 0 goes straight to MOSI; the register keeps the remaining 31.
                shreg_nxt   = i_rom_data[31:1];
                mosi_nxt    = i_rom_data[0];
                le_nxt      = 1'b0;
                spi_clk_nxt = 1'b0;
                cnt_nxt     = '0;
                bit_cnt_nxt = '0;
                state_nxt   = SHIFT;
            end
            SHIFT: begin
                if (cnt == DIV_LAST) begin
                    cnt_nxt = '0;
                    if (!o_spi_clk) begin
                        spi_clk_nxt = 1'b1;
                    end else begin
                        // Falling transition: MOSI advances together with SPI_CLK going low.
                        spi_clk_nxt = 1'b0;
                        mosi_nxt    = shreg[0];
                        shreg_nxt   = {1'b0, shreg[30:1]};
                        if (bit_cnt == 5'd31) begin
                            le_nxt    = 1'b1;
                            state_nxt = LATCH;
                        end else begin
                            bit_cnt_nxt = bit_cnt + 5'd1;
                        end
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            LATCH: begin
                if (cnt == LE_LAST) begin
                    cnt_nxt = '0;
                    if (o_rom_addr == LAST_ADDR) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                        addr_nxt  = '0;
                    end else begin
                        addr_nxt  = o_rom_addr + 3'd1;
                        state_nxt = LOAD;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cdce62002_spi_ctrl.sv
// Self-checking bench: two controller instances (default and minimal parameters)
// observed by a bus monitor and compared against ROM contents and cycle arithmetic.
module tb_cdce62002_spi_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  start;
    logic [2:0]  addr  [2];
    logic [31:0] rdata [2];
    logic [1:0]  spi_clk, mosi, le, busy, done;
    logic [31:0] rom [2][8];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    assign rdata[0] = rom[0][addr[0]];
    assign rdata[1] = rom[1][addr[1]];

    cdce62002_spi_ctrl u_a (
        .i_clk(clk), .i_rst(rst), .i_start(start[0]), .o_rom_addr(addr[0]),
        .i_rom_data(rdata[0]), .o_spi_clk(spi_clk[0]), .o_spi_mosi(mosi[0]),
        .o_spi_le(le[0]), .o_busy(busy[0]), .o_done(done[0])
    );

    cdce62002_spi_ctrl #(.CLK_DIV(1), .NUM_WORDS(1), .LE_CYCLES(1)) u_b (
        .i_clk(clk), .i_rst(rst), .i_start(start[1]), .o_rom_addr(addr[1]),
        .i_rom_data(rdata[1]), .o_spi_clk(spi_clk[1]), .o_spi_mosi(mosi[1]),
        .o_spi_le(le[1]), .o_busy(busy[1]), .o_done(done[1])
    );

    // Bus monitor: records words seen on the SPI pins and timing of LE/busy/done.
    int          cyc = 0;
    logic [1:0]  p_clk, p_mosi, p_le, p_busy;
    logic [31:0] cur_word [2];
    int          cur_bits [2];
    logic [31:0] words    [2][16];
    int          wbits    [2][16];
    int          low_len  [2][16];
    int          gap_len  [2][16];
    int          word_cnt [2], gap_cnt [2], low_run [2], high_run [2];
    int          viol [2], busy_bad [2], done_cnt [2], rise_cnt [2];
    int          done_cyc [2][8];
    int          rise_cyc [2][8];

    always @(posedge clk) begin
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (spi_clk[d] && (mosi[d] !== p_mosi[d])) viol[d]++;
            if (!p_clk[d] && spi_clk[d]) begin
                if (cur_bits[d] < 32) cur_word[d][cur_bits[d]] = mosi[d];
                cur_bits[d]++;
            end
            if (!le[d]) low_run[d]++; else high_run[d]++;
            if (!p_le[d] && le[d]) begin
                if (word_cnt[d] < 16) begin
                    words[d][word_cnt[d]]   = cur_word[d];
                    wbits[d][word_cnt[d]]   = cur_bits[d];
                    low_len[d][word_cnt[d]] = low_run[d];
                end
                word_cnt[d]++;
                cur_word[d] = '0;
                cur_bits[d] = 0;
                high_run[d] = 1;
            end
            if (p_le[d] && !le[d]) begin
                if (word_cnt[d] > 0 && gap_cnt[d] < 16) begin
                    gap_len[d][gap_cnt[d]] = high_run[d];
                    gap_cnt[d]++;
                end
                low_run[d] = 1;
            end
            if (!p_busy[d] && busy[d]) begin
                if (rise_cnt[d] < 8) rise_cyc[d][rise_cnt[d]] = cyc;
                rise_cnt[d]++;
            end
            if (done[d]) begin
                if (busy[d]) busy_bad[d]++;
                if (done_cnt[d] < 8) done_cyc[d][done_cnt[d]] = cyc;
                done_cnt[d]++;
            end
            p_clk[d]  = spi_clk[d];
            p_mosi[d] = mosi[d];
            p_le[d]   = le[d];
            p_busy[d] = busy[d];
        end
    end

    task automatic mon_clear(input int d);
        word_cnt[d] = 0; gap_cnt[d] = 0; low_run[d] = 0; high_run[d] = 0;
        viol[d] = 0; busy_bad[d] = 0; done_cnt[d] = 0; rise_cnt[d] = 0;
        cur_word[d] = '0; cur_bits[d] = 0;
        p_clk[d] = spi_clk[d]; p_mosi[d] = mosi[d]; p_le[d] = le[d]; p_busy[d] = busy[d];
    endtask

    task automatic randomize_rom(input int d);
        for (int i = 0; i < 8; i++) rom[d][i] = $urandom;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        for (int d = 0; d < 2; d++) begin
            total++;
            if ({addr[d], spi_clk[d], mosi[d], le[d], busy[d], done[d]} !== 8'b000_0_0_1_0_0)
                $display("FAIL reset_values dut%0d: got %b expected 00000100", d,
                         {addr[d], spi_clk[d], mosi[d], le[d], busy[d], done[d]});
            else passed++;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs one full sequence on dut d; optionally pulses start again inside word inject_word.
    task automatic run_seq(input int d, input int inject_word, input string tag);
        int cd, le_c, nw, per, n0, budget, bad_bits, bad_low, bad_gap;
        bit injected;
        cd   = (d == 0) ? 4 : 1;
        le_c = (d == 0) ? 4 : 1;
        nw   = (d == 0) ? 6 : 1;
        per  = 1 + 64 * cd + le_c;
        injected = 1'b0;
        mon_clear(d);
        @(posedge clk); #2;
        n0 = cyc;
        start[d] = 1'b1;
        @(posedge clk); #2;
        start[d] = 1'b0;
        budget = nw * per + 50;
        while (done_cnt[d] == 0 && budget > 0) begin
            if (inject_word >= 0 && !injected && word_cnt[d] == inject_word && !le[d]) begin
                repeat (37) @(posedge clk);
                #2 start[d] = 1'b1;
                @(posedge clk);
                #2 start[d] = 1'b0;
                injected = 1'b1;
            end
            @(posedge clk); #2;
            budget--;
        end
        total++;
        if (done_cnt[d] == 0) $display("FAIL %s timeout: no done within %0d cycles", tag, nw * per + 50);
        else passed++;
        repeat (per + 10) @(posedge clk);
        #2;

        total++;
        if (rise_cnt[d] < 1 || rise_cyc[d][0] - n0 !== 1)
            $display("FAIL %s busy_latency: got %0d expected 1", tag, rise_cyc[d][0] - n0);
        else passed++;
        total++;
        if (done_cnt[d] !== 1) $display("FAIL %s done_count: got %0d expected 1", tag, done_cnt[d]);
        else passed++;
        total++;
        if (done_cyc[d][0] - rise_cyc[d][0] !== nw * per)
            $display("FAIL %s seq_length: got %0d expected %0d", tag, done_cyc[d][0] - rise_cyc[d][0], nw * per);
        else passed++;
        total++;
        if (word_cnt[d] !== nw) $display("FAIL %s word_count: got %0d expected %0d", tag, word_cnt[d], nw);
        else passed++;
        for (int i = 0; i < nw && i < word_cnt[d]; i++) begin
            total++;
            if (words[d][i] !== rom[d][i])
                $display("FAIL %s word%0d: got %h expected %h", tag, i, words[d][i], rom[d][i]);
            else passed++;
        end
        bad_bits = 0; bad_low = 0; bad_gap = 0;
        for (int i = 0; i < nw && i < word_cnt[d]; i++) begin
            if (wbits[d][i] != 32) bad_bits++;
            if (low_len[d][i] != 64 * cd) bad_low++;
        end
        for (int i = 0; i < gap_cnt[d]; i++) if (gap_len[d][i] != le_c + 1) bad_gap++;
        total++;
        if (bad_bits !== 0) $display("FAIL %s rising_edges: %0d words without 32 edges, expected 0", tag, bad_bits);
        else passed++;
        total++;
        if (bad_low !== 0) $display("FAIL %s le_low_len: %0d windows not %0d cycles, expected 0", tag, bad_low, 64 * cd);
        else passed++;
        total++;
        if (gap_cnt[d] !== nw - 1 || bad_gap !== 0)
            $display("FAIL %s le_high_gaps: got %0d gaps (%0d wrong) expected %0d of %0d cycles",
                     tag, gap_cnt[d], bad_gap, nw - 1, le_c + 1);
        else passed++;
        total++;
        if (viol[d] !== 0) $display("FAIL %s mosi_stability: got %0d changes while clk high, expected 0", tag, viol[d]);
        else passed++;
        total++;
        if (busy_bad[d] !== 0 || busy[d] !== 1'b0 || le[d] !== 1'b1)
            $display("FAIL %s end_state: busy_bad=%0d busy=%b le=%b expected 0/0/1", tag, busy_bad[d], busy[d], le[d]);
        else passed++;
    endtask

    task automatic test_default();
        rom[0][0] = 32'h4008_0000; rom[0][1] = 32'h0E40_0229; rom[0][2] = 32'h8006_D1C1;
        rom[0][3] = 32'h4018_0000; rom[0][4] = 32'hF800_0000; rom[0][5] = 32'h4008_0000;
        rom[0][6] = 32'hDEAD_BEEF; rom[0][7] = 32'h1234_5678;
        run_seq(0, -1, "default");
    endtask

    task automatic test_start_ignored();
        randomize_rom(0);
        run_seq(0, 3, "mid_start");
    endtask

    task automatic test_reset_mid();
        int budget;
        randomize_rom(0);
        mon_clear(0);
        @(posedge clk); #2 start[0] = 1'b1;
        @(posedge clk); #2 start[0] = 1'b0;
        budget = 1000;
        while (!(word_cnt[0] == 2 && !le[0]) && budget > 0) begin
            @(posedge clk); #2;
            budget--;
        end
        total++;
        if (budget == 0) $display("FAIL reset_mid wait: word 2 never started, expected within 1000 cycles");
        else passed++;
        repeat ($urandom_range(5, 200)) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        total++;
        if ({addr[0], spi_clk[0], le[0], busy[0], done[0]} !== 7'b000_0_1_0_0)
            $display("FAIL reset_mid outputs: got %b expected 0000100",
                     {addr[0], spi_clk[0], le[0], busy[0], done[0]});
        else passed++;
        #3 rst = 1'b0;
        randomize_rom(0);
        run_seq(0, -1, "after_rst");
    endtask

    task automatic test_small();
        for (int r = 0; r < 2; r++) begin
            randomize_rom(1);
            run_seq(1, -1, "small");
        end
    endtask

    task automatic test_back_to_back();
        int n0, budget;
        randomize_rom(1);
        mon_clear(1);
        @(posedge clk); #2;
        n0 = cyc;
        start[1] = 1'b1;
        budget = 400;
        while (done_cnt[1] < 3 && budget > 0) begin
            @(posedge clk); #2;
            budget--;
        end
        start[1] = 1'b0;
        total++;
        if (budget == 0) $display("FAIL b2b timeout: got %0d done pulses expected 3", done_cnt[1]);
        else passed++;
        repeat (100) @(posedge clk);
        #2;
        total++;
        if (done_cnt[1] !== 3 || rise_cnt[1] !== 3)
            $display("FAIL b2b counts: got done=%0d busy_rises=%0d expected 3/3", done_cnt[1], rise_cnt[1]);
        else passed++;
        total++;
        if (rise_cyc[1][0] - n0 !== 1)
            $display("FAIL b2b first_latency: got %0d expected 1", rise_cyc[1][0] - n0);
        else passed++;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (done_cyc[1][k] - rise_cyc[1][k] !== 66)
                $display("FAIL b2b seq%0d_length: got %0d expected 66", k, done_cyc[1][k] - rise_cyc[1][k]);
            else passed++;
        end
        for (int k = 0; k < 2; k++) begin
            total++;
            if (rise_cyc[1][k + 1] - done_cyc[1][k] !== 2)
                $display("FAIL b2b gap%0d: restart %0d cycles after done, expected 2",
                         k, rise_cyc[1][k + 1] - done_cyc[1][k]);
            else passed++;
        end
        for (int k = 0; k < word_cnt[1] && k < 3; k++) begin
            total++;
            if (words[1][k] !== rom[1][0])
                $display("FAIL b2b word%0d: got %h expected %h", k, words[1][k], rom[1][0]);
            else passed++;
        end
    endtask

    initial begin
        start = 2'b00;
        for (int i = 0; i < 8; i++) begin
            rom[0][i] = '0;
            rom[1][i] = '0;
        end
        test_reset();
        test_default();
        test_start_ignored();
        test_reset_mid();
        test_small();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
